sobel_window_gen: RTL and testbench

//  Streaming 3x3 window generator that sits directly upstream of the Sobel/ReRAM edge accelerator.
//  - Accepts one raster-order 8-bit pixel per handshake.
//  - Buffers the two previous image rows.
//  - Emits each fully-populated 3x3 neighbourhood as a packed 72-bit bus, ready for the accelerator's pixel_window input.
//  - Valid-only windows: no border padding, so (IMG_W-2)*(IMG_H-2) windows are produced per frame.

---
 rtl/sobel_pkg.sv | 14 +
 rtl/sobel_linebuf.sv | 19 +
 rtl/sobel_window_gen.sv | 67 ++++++
 tb/tb_sobel_window_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: pixel/window widths and window bit offsets shared with the accelerator unpack logic
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;
  localparam int P00 = 8 * PIX_W;
  localparam int P01 = 7 * PIX_W;
  localparam int P02 = 6 * PIX_W;
  localparam int P10 = 5 * PIX_W;
  localparam int P11 = 4 * PIX_W;
  localparam int P12 = 3 * PIX_W;
  localparam int P20 = 2 * PIX_W;
  localparam int P21 = PIX_W;
  localparam int P22 = 0;
endpackage

// File: rtl/sobel_linebuf.sv
// sobel_linebuf: one image row of pixels, read-before-write single-port RAM
module sobel_linebuf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W = PIX_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  assign o_rdata = r_mem[i_addr];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 valid-only window generator feeding the Sobel accelerator
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = sobel_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_pix_in,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  output logic [9*PIX_W-1:0] o_win_out,
  output logic             o_win_valid,
  input  logic             i_win_ready,
  output logic             o_frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [PIX_W-1:0] w_a, w_b;
  logic [3*PIX_W-1:0] r_w0, r_w1, r_w2;
  logic r_vld, r_fd, w_acc, w_eol, w_eof, w_full;
  assign o_pix_ready = !r_vld || i_win_ready;
  assign w_acc = i_pix_valid && o_pix_ready;
  assign w_col = i_sof ? '0 : r_col;
  assign w_row = i_sof ? '0 : r_row;
  assign w_eol = w_col == C_LAST;
  assign w_eof = w_eol && w_row == R_LAST;
  assign w_full = w_row >= RW'(2) && w_col >= CW'(2);
  sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb_top (
    .clk(clk), .i_we(w_acc), .i_addr(w_col), .i_wdata(w_b), .o_rdata(w_a)
  );
  sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb_mid (
    .clk(clk), .i_we(w_acc), .i_addr(w_col), .i_wdata(i_pix_in), .o_rdata(w_b)
  );
  // the window registers double as the output register: they only shift when the output is free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_w0 <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
      r_vld <= 1'b0;
      r_fd <= 1'b0;
    end else begin
      r_fd <= w_acc && w_eof;
      if (w_acc) begin
        r_col <= w_eol ? '0 : w_col + 1'b1;
        r_row <= w_eof ? '0 : w_eol ? w_row + 1'b1 : w_row;
        r_w0 <= {r_w0[2*PIX_W-1:0], w_a};
        r_w1 <= {r_w1[2*PIX_W-1:0], w_b};
        r_w2 <= {r_w2[2*PIX_W-1:0], i_pix_in};
        r_vld <= w_full;
      end else if (i_win_ready) begin
        r_vld <= 1'b0;
      end
    end
  end
  assign o_win_out = {r_w0, r_w1, r_w2};
  assign o_win_valid = r_vld;
  assign o_frame_done = r_fd;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: scoreboard bench for the 3x3 window generator on an 8x4 ramp image
module tb_sobel_window_gen;
  import sobel_pkg::*;
  localparam int W = 8;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN = 72'h000102_101112_202122;
  logic clk = 1'b0;
  logic rst, sof, pix_valid, pix_ready, win_valid, win_ready, frame_done;
  logic [7:0] pix_in;
  logic [71:0] win_out;
  always #5 clk = ~clk;
  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .i_sof(sof), .i_pix_in(pix_in), .i_pix_valid(pix_valid),
    .o_pix_ready(pix_ready), .o_win_out(win_out), .o_win_valid(win_valid),
    .i_win_ready(win_ready), .o_frame_done(frame_done)
  );
  typedef struct {int idx; logic [71:0] win;} vec_t;
  vec_t tbl[3];
  logic [71:0] q[$];
  logic [71:0] got[$];
  logic [7:0] img[H][W];
  int mr, mc, n_vec, n_err, n_win, fd_cnt;
  logic fd_exp, stall_prev;
  logic [71:0] last_win, fd_win;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [71:0] mk_win(input int r, input int c);
    logic [71:0] w;
    w[P00+:8] = img[r-2][c-2];
    w[P01+:8] = img[r-2][c-1];
    w[P02+:8] = img[r-2][c];
    w[P10+:8] = img[r-1][c-2];
    w[P11+:8] = img[r-1][c-1];
    w[P12+:8] = img[r-1][c];
    w[P20+:8] = img[r][c-2];
    w[P21+:8] = img[r][c-1];
    w[P22+:8] = img[r][c];
    return w;
  endfunction
  task automatic step(input logic v, input logic [7:0] p, input logic s, input logic wr, output logic acc);
    logic cons;
    pix_valid = v;
    pix_in = p;
    sof = s;
    win_ready = wr;
    #1;
    acc = v && pix_ready;
    cons = win_valid && wr;
    chk("frame_done", frame_done, fd_exp);
    if (frame_done) begin
      fd_cnt++;
      fd_win = win_out;
    end
    if (win_valid && stall_prev) chk("hold", win_out, last_win);
    if (win_valid && !wr) chk("stall_ready", pix_ready, 1'b0);
    stall_prev = win_valid && !wr;
    last_win = win_out;
    if (cons) begin
      if (q.size() == 0) chk("extra_win", 1, 0);
      else chk("win", win_out, q.pop_front());
      got.push_back(win_out);
      n_win++;
    end
    fd_exp = 1'b0;
    if (acc) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) q.push_back(mk_win(mr, mc));
      fd_exp = mr == H - 1 && mc == W - 1;
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else mc++;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    sof = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mr = 0;
    mc = 0;
    fd_exp = 1'b0;
    stall_prev = 1'b0;
    #1;
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_win_out", win_out, '0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b1);
  endtask
  task automatic frame(input logic s0, input int stall_at, input int npix);
    for (int i = 0; i < npix; i++) begin
      int tries;
      logic acc;
      tries = 0;
      acc = 1'b0;
      while (!acc) begin
        step(1'b1, 8'((i / W) * 16 + i % W), s0 && i == 0, !(i == stall_at && tries < 5), acc);
        tries++;
        if (!acc && tries > 50) begin
          chk("accept_timeout", 0, 1);
          acc = 1'b1;
        end
      end
    end
  endtask
  task automatic drain(input int n);
    logic a;
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b1, a);
    chk("queue_empty", q.size(), 0);
  endtask
  task automatic clear_stats();
    n_win = 0;
    fd_cnt = 0;
    got.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{0, FIRST_WIN};
    tbl[1] = '{1, 72'h010203_111213_212223};
    tbl[2] = '{11, 72'h151617_252627_353637};
    do_reset();
    clear_stats();
    frame(1'b1, -1, W * H);
    drain(3);
    chk("win_count_ramp", n_win, 12);
    chk("fd_count_ramp", fd_cnt, 1);
    chk("fd_window", fd_win, tbl[2].win);
    for (int i = 0; i < 3; i++) begin
      if (got.size() > tbl[i].idx) chk("ramp_table", got[tbl[i].idx], tbl[i].win);
      else chk("ramp_table_missing", got.size(), tbl[i].idx + 1);
    end
    clear_stats();
    frame(1'b0, 20, W * H);
    drain(3);
    chk("win_count_bp", n_win, 12);
    chk("fd_count_bp", fd_cnt, 1);
    if (got.size() > 0) chk("next_frame_first", got[0], FIRST_WIN);
    else chk("next_frame_missing", 0, 1);
    clear_stats();
    frame(1'b0, -1, 21);
    do_reset();
    clear_stats();
    frame(1'b0, -1, W * H);
    drain(3);
    chk("win_count_rst", n_win, 12);
    if (got.size() > 0) chk("rst_frame_first", got[0], FIRST_WIN);
    else chk("rst_frame_missing", 0, 1);
    clear_stats();
    frame(1'b0, -1, 11);
    drain(2);
    chk("win_count_partial", n_win, 0);
    frame(1'b1, -1, W * H);
    drain(3);
    chk("win_count_sof", n_win, 12);
    chk("fd_count_sof", fd_cnt, 1);
    if (got.size() > 0) chk("sof_frame_first", got[0], FIRST_WIN);
    else chk("sof_frame_missing", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
